// File: rtl/trap_controller_if.sv
// Bundle between the CONTROL stage sequencer and the trap controller.
// The master drives requests and fault/irq lines; the slave returns the decision.
interface trap_controller_if #(
  parameter int NUM_FAULTS  = 8,
  parameter int NUM_IRQ     = 4,
  parameter int CAUSE_WIDTH = 4
);
  logic                   start;
  logic [NUM_FAULTS-1:0]  fault_in;
  logic                   clear_faults;
  logic [NUM_IRQ-1:0]     irq;
  logic [NUM_IRQ-1:0]     irq_enable;
  logic                   global_ie;
  logic                   trap_return;
  logic [1:0]             op;
  logic [CAUSE_WIDTH-1:0] cause;
  logic                   busy;
  logic                   in_trap;
  logic                   halted;
  logic [NUM_IRQ-1:0]     pending;

  modport master (
    output start, fault_in, clear_faults, irq,
    output irq_enable, global_ie, trap_return,
    input  op, cause, busy, in_trap, halted, pending
  );

  modport slave (
    input  start, fault_in, clear_faults, irq,
    input  irq_enable, global_ie, trap_return,
    output op, cause, busy, in_trap, halted, pending
  );
endinterface

// File: rtl/trap_controller.sv
// Trap controller: fault latch, irq arbitration, nesting and double-fault halt.
// Define IRQ_SYNC_EN to pass irq through a two-flop synchroniser.
module trap_controller #(
  parameter int NUM_FAULTS  = 8,
  parameter int NUM_IRQ     = 4,
  parameter int CAUSE_WIDTH = 4
) (
  input logic clk,
  input logic reset,
  trap_controller_if.slave tc
);
  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_e;

  localparam logic [1:0] OP_FAULT = 2'b00;
  localparam logic [1:0] OP_IRQ   = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_NORM  = 2'b11;

  state_e                 state_q;
  logic [1:0]             op_q;
  logic [CAUSE_WIDTH-1:0] cause_q;
  logic                   in_trap_q;
  logic                   halted_q;
  logic [NUM_FAULTS-1:0]  latch_q;
  logic [NUM_FAULTS-1:0]  latch_d;
  logic [NUM_IRQ-1:0]     irq_s;
  logic [NUM_IRQ-1:0]     gated;
  logic [CAUSE_WIDTH-1:0] fault_idx;
  logic [CAUSE_WIDTH-1:0] irq_idx;
  logic                   eval;
  logic                   any_fault;
  logic                   fault_trap;
  logic                   dbl_fault;
  logic                   irq_trap;
  logic                   busy;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= tc.irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = tc.irq;
`endif

  assign gated = irq_s & tc.irq_enable;

  // Lowest fault index wins, highest irq line wins.
  always_comb begin
    fault_idx = '0;
    for (int i = NUM_FAULTS - 1; i >= 0; i--)
      if (latch_q[i]) fault_idx = CAUSE_WIDTH'(i);
    irq_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (gated[i]) irq_idx = CAUSE_WIDTH'(i);
  end

  assign eval       = (state_q == EVAL);
  assign any_fault  = |latch_q;
  assign fault_trap = eval & ~halted_q & any_fault & ~in_trap_q;
  assign dbl_fault  = eval & ~halted_q & any_fault & in_trap_q;
  assign irq_trap   = eval & ~halted_q & ~any_fault & ~in_trap_q
                    & tc.global_ie & (|gated);

  // New fault pulses survive a same-cycle clear.
  assign latch_d = (latch_q & ~{NUM_FAULTS{tc.clear_faults | fault_trap}})
                 | tc.fault_in;

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      IDLE:    busy = tc.start;
      EVAL:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_NORM;
      cause_q   <= '0;
      in_trap_q <= 1'b0;
      halted_q  <= 1'b0;
      latch_q   <= '0;
    end else begin
      latch_q <= latch_d;
      if (fault_trap | irq_trap) in_trap_q <= 1'b1;
      else if (tc.trap_return)   in_trap_q <= 1'b0;
      if (dbl_fault) halted_q <= 1'b1;
      unique case (state_q)
        IDLE: if (tc.start) state_q <= EVAL;
        EVAL: begin
          state_q <= RESP;
          unique case (1'b1)
            halted_q:   op_q <= OP_HALT;
            dbl_fault:  op_q <= OP_HALT;
            fault_trap: begin
              op_q    <= OP_FAULT;
              cause_q <= fault_idx;
            end
            irq_trap: begin
              op_q    <= OP_IRQ;
              cause_q <= irq_idx;
            end
            default:    op_q <= OP_NORM;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tc.op      = op_q;
  assign tc.cause   = cause_q;
  assign tc.busy    = busy;
  assign tc.in_trap = in_trap_q;
  assign tc.halted  = halted_q;
  assign tc.pending = gated;
endmodule

// File: tb/tb_trap_controller.sv
// Vector table plus scoreboard bench for trap_controller.
// Hand sequences cover reset, halt stickiness and handshake corners.
module tb_trap_controller;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  trap_controller_if #(.NUM_FAULTS(8), .NUM_IRQ(4), .CAUSE_WIDTH(4)) bus ();

  trap_controller #(
    .NUM_FAULTS(8),
    .NUM_IRQ(4),
    .CAUSE_WIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tc   (bus.slave)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] cause;
    logic       it;
    logic       hl;
  } exp_t;

  typedef struct {
    logic [7:0] fault;
    logic       clr;
    logic       ret;
    logic [3:0] irq;
    logic [3:0] en;
    logic       gie;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic compare_result(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_op"}, 32'(bus.op), 32'(e.op));
      chk({tag, "_cause"}, 32'(bus.cause), 32'(e.cause));
      chk({tag, "_in_trap"}, 32'(bus.in_trap), 32'(e.it));
      chk({tag, "_halted"}, 32'(bus.halted), 32'(e.hl));
    end
  endtask

  task automatic run_decision(string tag, exp_t e, bit ret_eval, bit hold);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    #1 chk({tag, "_busyN"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = hold;
    bus.trap_return = ret_eval;
    #1 chk({tag, "_busyN1"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.trap_return = 1'b0;
    #1 chk({tag, "_busyN2"}, 32'(bus.busy), 32'd0);
    compare_result(tag);
    if (hold) begin
      sb.push_back(e);
      @(negedge clk);
      #1 chk({tag, "_rebusy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk({tag, "_rebusyE"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      #1 compare_result({tag, "_re"});
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse(logic [7:0] f, logic clr, logic ret);
    @(negedge clk);
    bus.fault_in = f;
    bus.clear_faults = clr;
    bus.trap_return = ret;
    @(negedge clk);
    bus.fault_in = '0;
    bus.clear_faults = 1'b0;
    bus.trap_return = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.fault_in = '0;
    bus.clear_faults = 1'b0;
    bus.irq = '0;
    bus.irq_enable = '0;
    bus.global_ie = 1'b0;
    bus.trap_return = 1'b0;

    //            fault       clr   ret   irq      en       gie   op     cause it    hl
    vecs[0]  = '{8'h00,      1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, '{2'b11, 4'd0, 1'b0, 1'b0}};
    vecs[1]  = '{8'b0000_0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, '{2'b00, 4'd2, 1'b1, 1'b0}};
    vecs[2]  = '{8'h00,      1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, '{2'b11, 4'd2, 1'b0, 1'b0}};
    vecs[3]  = '{8'b0000_0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, '{2'b00, 4'd2, 1'b1, 1'b0}};
    vecs[4]  = '{8'h00,      1'b0, 1'b1, 4'b1010, 4'b1111, 1'b1, '{2'b01, 4'd3, 1'b1, 1'b0}};
    vecs[5]  = '{8'h00,      1'b0, 1'b1, 4'b1010, 4'b1111, 1'b0, '{2'b11, 4'd3, 1'b0, 1'b0}};
    vecs[6]  = '{8'b0000_0010, 1'b0, 1'b0, 4'b1010, 4'b1111, 1'b1, '{2'b00, 4'd1, 1'b1, 1'b0}};
    vecs[7]  = '{8'h00,      1'b0, 1'b1, 4'b1010, 4'b0010, 1'b1, '{2'b01, 4'd1, 1'b1, 1'b0}};
    vecs[8]  = '{8'h00,      1'b0, 1'b0, 4'b0001, 4'b1111, 1'b1, '{2'b11, 4'd1, 1'b1, 1'b0}};
    vecs[9]  = '{8'b0010_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, '{2'b10, 4'd1, 1'b1, 1'b1}};
    vecs[10] = '{8'h00,      1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, '{2'b10, 4'd1, 1'b0, 1'b1}};
    vecs[11] = '{8'b0000_0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, '{2'b10, 4'd1, 1'b0, 1'b1}};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_op", 32'(bus.op), 32'h3);
    chk("rst_cause", 32'(bus.cause), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_in_trap", 32'(bus.in_trap), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);

    for (int i = 0; i < 12; i++) begin
      bus.irq = vecs[i].irq;
      bus.irq_enable = vecs[i].en;
      bus.global_ie = vecs[i].gie;
      pulse(vecs[i].fault, vecs[i].clr, vecs[i].ret);
      chk($sformatf("v%0d_pending", i), 32'(bus.pending),
          32'(vecs[i].irq & vecs[i].en));
      run_decision($sformatf("v%0d", i), vecs[i].e, 1'b0, 1'b0);
    end

    // Only reset clears a double-fault halt.
    bus.irq = '0;
    bus.irq_enable = '0;
    do_reset();
    #1 chk("halt_rst", 32'(bus.halted), 32'h0);
    run_decision("post_rst", '{2'b11, 4'd0, 1'b0, 1'b0}, 1'b0, 1'b0);

    // Reset during EVAL aborts the pending fault trap.
    pulse(8'b0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_op", 32'(bus.op), 32'h3);
    chk("abort_in_trap", 32'(bus.in_trap), 32'h0);

    // Trap issued on the same edge as trap_return keeps in_trap set.
    pulse(8'b0000_1000, 1'b0, 1'b0);
    run_decision("trap_vs_ret", '{2'b00, 4'd3, 1'b1, 1'b0}, 1'b1, 1'b0);

    // Start held through RESP only restarts after IDLE.
    pulse(8'h00, 1'b0, 1'b1);
    run_decision("hold", '{2'b11, 4'd3, 1'b0, 1'b0}, 1'b0, 1'b1);

    // irq to pending latency.
    @(negedge clk);
    bus.irq = 4'b0001;
    bus.irq_enable = 4'b0001;
`ifdef IRQ_SYNC_EN
    #1 chk("sync_p0", 32'(bus.pending), 32'h0);
    @(negedge clk);
    #1 chk("sync_p1", 32'(bus.pending), 32'h0);
    @(negedge clk);
    #1 chk("sync_p2", 32'(bus.pending), 32'h1);
`else
    #1 chk("comb_pending", 32'(bus.pending), 32'h1);
    bus.irq_enable = 4'b0000;
    #1 chk("comb_masked", 32'(bus.pending), 32'h0);
`endif

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover: got %0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
